// File: rtl/mem_pkg.sv
// Shared types and constants for the DDR3-side request sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: FSM state enum, wrapper command encodings, default bus widths.
package mem_pkg;

  localparam int ADDR_W_DEF = 26;  // word address, 4-byte granularity
  localparam int DATA_W_DEF = 32;  // word data

  // Wrapper command encoding on mem_cmd
  localparam logic MEM_CMD_WRITE = 1'b0;
  localparam logic MEM_CMD_READ  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_CMD,
    RD_WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/mem_req_sequencer.sv
// Single-outstanding word read/write sequencer in front of the DDR3 UI wrapper.
// Latency: rsp_valid 1 cycle after the read-return, or after the later of the two write accepts.
// Backpressure: req_ready only in IDLE with calibration done; wrapper stalls hold the request.
//
// Ports:
//   ui_clk, sync_rst                 sole clock, synchronous active-high reset
//   calibrated                       memory calibration complete (gates new acceptance only)
//   req_valid/req_ready/req_we/
//   req_addr/req_wdata               core request handshake
//   rsp_valid/rsp_rdata/rsp_err      one-cycle registered completion
//   mem_en/mem_wea/mem_cmd/
//   mem_addr/mem_din                 command and write-data strobes to the wrapper
//   mem_dout/mem_cmd_rdy/
//   mem_write_rdy/mem_read_arrived   wrapper accepts and read return
//
// Build option: define MEM_TIMEOUT_EN to add a TIMEOUT_CYCLES watchdog that
// completes a stuck transaction with rsp_err=1. Without it rsp_err is 0 and the
// sequencer waits indefinitely for the wrapper.
module mem_req_sequencer
  import mem_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              ui_clk,
  input  logic              sync_rst,
  input  logic              calibrated,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_wea,
  output logic              mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              mem_cmd_rdy,
  input  logic              mem_write_rdy,
  input  logic              mem_read_arrived
);

  state_t              r_state;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_mem_en;
  logic                r_mem_wea;
  logic                r_mem_cmd;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_din;
  logic                r_cmd_done;
  logic                r_wr_done;

  logic w_accept;
  logic w_cmd_acc;
  logic w_wr_acc;
  logic w_cmd_done;
  logic w_wr_done;
  logic w_busy;
  logic w_normal_done;

  assign w_accept   = (r_state == IDLE) && r_req_ready && req_valid;
  // Each strobe is only held until its own accept, so strobe && rdy is the accept.
  assign w_cmd_acc  = r_mem_en  && mem_cmd_rdy;
  assign w_wr_acc   = r_mem_wea && mem_write_rdy;
  // Done flags include this cycle's accept so a same-cycle pair completes at once.
  assign w_cmd_done = r_cmd_done || w_cmd_acc;
  assign w_wr_done  = r_wr_done  || w_wr_acc;
  assign w_busy     = (r_state == WRITE) || (r_state == RD_CMD) || (r_state == RD_WAIT);
  assign w_normal_done = ((r_state == WRITE) && w_cmd_done && w_wr_done) ||
                         (((r_state == RD_CMD) || (r_state == RD_WAIT)) && mem_read_arrived);

`ifdef MEM_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] r_to_cnt;
  logic            r_rsp_err;
  logic            w_to_hit;

  // A genuine completion in the expiry cycle wins over the watchdog.
  assign w_to_hit = w_busy && !w_normal_done && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign rsp_err  = r_rsp_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0) || w_busy || w_normal_done;
  assign rsp_err          = 1'b0;
`endif

  always_ff @(posedge ui_clk) begin
    if (sync_rst) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_mem_en    <= 1'b0;
      r_mem_wea   <= 1'b0;
      r_mem_cmd   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_din   <= '0;
      r_cmd_done  <= 1'b0;
      r_wr_done   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_to_cnt    <= '0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_rsp_err   <= 1'b0;
`endif
      unique case (r_state)
        IDLE: begin
          r_req_ready <= calibrated;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_mem_cmd   <= req_we ? MEM_CMD_WRITE : MEM_CMD_READ;
            // Address stays put until the next acceptance: the wrapper
            // lane-selects mem_dout from it combinationally.
            r_mem_addr  <= req_addr;
            r_mem_din   <= req_wdata;
            r_mem_en    <= 1'b1;
            r_mem_wea   <= req_we;
            r_cmd_done  <= 1'b0;
            r_wr_done   <= 1'b0;
            r_state     <= req_we ? WRITE : RD_CMD;
          end
        end

        WRITE: begin
          if (w_cmd_acc) begin
            r_mem_en   <= 1'b0;
            r_cmd_done <= 1'b1;
          end
          if (w_wr_acc) begin
            r_mem_wea <= 1'b0;
            r_wr_done <= 1'b1;
          end
          if (w_cmd_done && w_wr_done) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
            r_state     <= RESP;
          end
        end

        RD_CMD: begin
          // An early return is taken as the read data; the command is
          // considered consumed at that point.
          if (mem_read_arrived) begin
            r_mem_en    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= mem_dout;
            r_state     <= RESP;
          end else if (mem_cmd_rdy) begin
            r_mem_en <= 1'b0;
            r_state  <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (mem_read_arrived) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= mem_dout;
            r_state     <= RESP;
          end
        end

        RESP: begin
          r_req_ready <= calibrated;
          r_state     <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase

`ifdef MEM_TIMEOUT_EN
      if (w_accept) begin
        r_to_cnt <= '0;
      end else if (w_busy) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (w_to_hit) begin
        r_mem_en    <= 1'b0;
        r_mem_wea   <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= 1'b1;
        r_rsp_rdata <= '0;
        r_state     <= RESP;
      end
`endif
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign mem_en    = r_mem_en;
  assign mem_wea   = r_mem_wea;
  assign mem_cmd   = r_mem_cmd;
  assign mem_addr  = r_mem_addr;
  assign mem_din   = r_mem_din;

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Bench for mem_req_sequencer: acts as core and as DDR3 wrapper with a word memory model.
// Expected timing comes from the handshake rules: strobes last until their accept,
// response one cycle after the read return or the later write accept.
module tb_mem_req_sequencer;

  localparam int ADDR_W = 26;
  localparam int DATA_W = 32;

  logic              ui_clk = 1'b0;
  logic              sync_rst;
  logic              calibrated;
  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              mem_en;
  logic              mem_wea;
  logic              mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic              mem_cmd_rdy;
  logic              mem_write_rdy;
  logic              mem_read_arrived;

  int checks   = 0;
  int failures = 0;

  // Word memory behind the wrapper: address -> last written data
  logic [DATA_W-1:0] mem_model [int unsigned];

  always #5 ui_clk = ~ui_clk;

  mem_req_sequencer dut (
    .ui_clk           (ui_clk),
    .sync_rst         (sync_rst),
    .calibrated       (calibrated),
    .req_valid        (req_valid),
    .req_we           (req_we),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .req_ready        (req_ready),
    .rsp_valid        (rsp_valid),
    .rsp_rdata        (rsp_rdata),
    .rsp_err          (rsp_err),
    .mem_en           (mem_en),
    .mem_wea          (mem_wea),
    .mem_cmd          (mem_cmd),
    .mem_addr         (mem_addr),
    .mem_din          (mem_din),
    .mem_dout         (mem_dout),
    .mem_cmd_rdy      (mem_cmd_rdy),
    .mem_write_rdy    (mem_write_rdy),
    .mem_read_arrived (mem_read_arrived)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ui_clk);
    #1;
  endtask

  // Waits (bounded) for req_ready with req_valid already driven, then lets the
  // accepting edge pass. Returns in the first cycle after acceptance.
  task automatic handshake(output int waited);
    waited = 0;
    while (req_ready !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    chk("hs_timeout", 64'(waited < 50), 64'(1));
    tick();
    req_valid = 1'b0;
  endtask

  // One full transaction. dc/dw: cycle (from first strobe cycle) in which the
  // wrapper accepts the command / write data; dr: read return delay after the
  // command accept. drop_cal lowers calibrated for the whole transaction.
  task automatic do_txn(input bit we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] rdata,
                        input int dc, input int dw, input int dr,
                        input bit drop_cal, input int max_wait);
    int waited;
    int exp_rsp;
    int en_cnt = 0;
    int wea_cnt = 0;
    int rsp_cnt = 0;
    int rsp_j = -1;
    int busy_rdy = 0;
    logic ready_after = 1'bx;
    logic [DATA_W-1:0] got_rdata = 'x;
    logic got_err = 1'bx;
    bit addr_bad = 0;

    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    handshake(waited);
    chk("hs_wait", 64'(waited <= max_wait), 64'(1));
    chk("first_cycle_strobes", 64'({mem_en, mem_wea, mem_cmd}), 64'({1'b1, we, ~we}));
    if (we) chk("mem_din", 64'(mem_din), 64'(wdata));

    exp_rsp = we ? (((dc > dw) ? dc : dw) + 1) : (dc + dr + 1);
    if (drop_cal) calibrated = 1'b0;

    for (int j = 0; j <= exp_rsp + 1; j++) begin
      mem_cmd_rdy      = (j == dc);
      mem_write_rdy    = we && (j == dw);
      // Spurious returns during a write must be ignored
      mem_read_arrived = we ? 1'($urandom_range(0, 1)) : (j == dc + dr);
      mem_dout         = (!we && j == dc + dr) ? rdata : $urandom;
      if (mem_en === 1'b1) en_cnt++;
      if (mem_wea === 1'b1) wea_cnt++;
      if (mem_addr !== addr) addr_bad = 1;
      if (rsp_valid === 1'b1) begin
        rsp_cnt++;
        rsp_j     = j;
        got_rdata = rsp_rdata;
        got_err   = rsp_err;
      end
      if (j <= exp_rsp && req_ready !== 1'b0) busy_rdy++;
      if (j == exp_rsp + 1) ready_after = req_ready;
      tick();
    end
    mem_cmd_rdy      = 1'b0;
    mem_write_rdy    = 1'b0;
    mem_read_arrived = 1'b0;
    calibrated       = 1'b1;

    chk("en_cycles", 64'(en_cnt), 64'(dc + 1));
    chk("wea_cycles", 64'(wea_cnt), we ? 64'(dw + 1) : 64'(0));
    chk("addr_stable", 64'(addr_bad), 64'(0));
    chk("rsp_count", 64'(rsp_cnt), 64'(1));
    chk("rsp_time", 64'(rsp_j), 64'(exp_rsp));
    chk("rsp_rdata", 64'(got_rdata), we ? 64'(0) : 64'(rdata));
    chk("rsp_err", 64'(got_err), 64'(0));
    chk("busy_ready", 64'(busy_rdy), 64'(0));
    chk("ready_after", 64'(ready_after), 64'(!drop_cal));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int waited;
    bit seen;
    bit we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rd;
    int dc, dw, dr;

    sync_rst = 1'b1; calibrated = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; mem_dout = '0; mem_cmd_rdy = 1'b0;
    mem_write_rdy = 1'b0; mem_read_arrived = 1'b0;
    repeat (3) tick();

    // Reset values
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst_rsp_err",   64'(rsp_err),   64'(0));
    chk("rst_mem_en",    64'(mem_en),    64'(0));
    chk("rst_mem_wea",   64'(mem_wea),   64'(0));
    chk("rst_mem_cmd",   64'(mem_cmd),   64'(0));
    chk("rst_mem_addr",  64'(mem_addr),  64'(0));
    chk("rst_mem_din",   64'(mem_din),   64'(0));
    sync_rst = 1'b0;

    // Uncalibrated: a pending request must not be taken
    req_valid = 1'b1; req_we = 1'b1; req_addr = 26'h0000123; req_wdata = 32'hDEADBEEF;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (req_ready !== 1'b0 || mem_en !== 1'b0) seen = 1;
    end
    chk("uncal_blocked", 64'(seen), 64'(0));
    calibrated = 1'b1;
    do_txn(1'b1, 26'h0000123, 32'hDEADBEEF, '0, 0, 0, 0, 1'b0, 2);
    mem_model[32'h123] = 32'hDEADBEEF;

    // Write data accepted before the command
    wd = $urandom;
    do_txn(1'b1, 26'h0000124, wd, '0, 4, 1, 0, 1'b0, 3);
    mem_model[32'h124] = wd;

    // Slow read
    do_txn(1'b0, 26'h0000122, $urandom, 32'hCAFEF00D, 3, 0, 10, 1'b0, 3);

    // Reset while waiting for read data: no response, clean outputs
    req_valid = 1'b1; req_we = 1'b0; req_addr = 26'h0000077;
    handshake(waited);
    mem_cmd_rdy = 1'b1;
    tick();
    mem_cmd_rdy = 1'b0;
    tick();
    tick();
    sync_rst = 1'b1;
    tick();
    sync_rst = 1'b0;
    chk("rst_mid_ctrl", 64'({req_ready, rsp_valid, rsp_err, mem_en, mem_wea, mem_cmd}), 64'(0));
    chk("rst_mid_addr_data", 64'({mem_addr, mem_din}), 64'(0));
    chk("rst_mid_rdata", 64'(rsp_rdata), 64'(0));
    mem_read_arrived = 1'b1; mem_dout = $urandom;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      mem_read_arrived = 1'b0;
      if (rsp_valid !== 1'b0) seen = 1;
    end
    chk("no_rsp_after_rst", 64'(seen), 64'(0));
    do_txn(1'b0, 26'h0000123, $urandom, mem_model[32'h123], 1, 0, 2, 1'b0, 3);

    // Read return coinciding with the command accept
    do_txn(1'b0, 26'h0000124, $urandom, mem_model[32'h124], 2, 0, 0, 1'b0, 3);

    // Calibration lost mid-transaction: completes, but no new acceptance
    wd = $urandom;
    do_txn(1'b1, 26'h0000125, wd, '0, 2, 3, 0, 1'b1, 3);
    mem_model[32'h125] = wd;

    // Randomized traffic against the memory model
    for (int n = 0; n < 14; n++) begin
      we = 1'($urandom_range(0, 1));
      a  = 26'h0000120 + 26'($urandom_range(0, 7));
      dc = $urandom_range(0, 5);
      dw = $urandom_range(0, 5);
      dr = $urandom_range(0, 6);
      wd = $urandom;
      rd = mem_model.exists(32'(a)) ? mem_model[32'(a)] : $urandom;
      do_txn(we, a, wd, rd, dc, dw, dr, 1'b0, 3);
      if (we) mem_model[32'(a)] = wd;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
